frequency_analyzer_sequencer: RTL and testbench

Measurement controller for `frequency_analyzer`. It runs one gated measurement per request: clears the analyzer, enables it for a fixed gate window, waits for its counters to settle, then latches `f1_value` and `f2_value`. It also classifies which tone dominates. It sits between the capture-control logic and the analyzer, and is the only driver of the analyzer's `enable` and `clear`.

---
 rtl/freq_analyzer_pkg.sv | 30 +++
 rtl/freq_dominance_classifier.sv | 37 +++
 rtl/frequency_analyzer_sequencer.sv | 140 ++++++++++++++
 tb/tb_frequency_analyzer_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_analyzer_pkg.sv
// rtl/freq_analyzer_pkg.sv - shared types and constants for the frequency analyzer sequencer
//
// Purpose : state encoding, dominance codes and count width shared by the
//           sequencer top and its dominance classifier.
// Ports   : none (package).
package freq_analyzer_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    DOM_NONE  = 2'd0,
    DOM_F1    = 2'd1,
    DOM_F2    = 2'd2,
    DOM_EQUAL = 2'd3
  } dom_code_t;

  // States in which the down-counter paces the sequence and abort is honoured.
  function automatic logic is_timed(input seq_state_t s);
    return (s == CLEAR) || (s == GATE) || (s == SETTLE);
  endfunction

endpackage

// File: rtl/freq_dominance_classifier.sv
// rtl/freq_dominance_classifier.sv - combinational dominant-tone classifier
//
// Purpose : decides which of two tone counts dominates. A tone is present
//           when its count is at least MIN_COUNT (unsigned compare).
// Ports   : f1, f2    - tone counts
//           dominant  - DOM_NONE / DOM_F1 / DOM_F2 / DOM_EQUAL
module freq_dominance_classifier
  import freq_analyzer_pkg::*;
#(
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic [COUNT_W-1:0] f1,
  input  logic [COUNT_W-1:0] f2,
  output logic [1:0]         dominant
);

  localparam logic [COUNT_W-1:0] MIN_VAL = COUNT_W'(MIN_COUNT);

  logic f1_present;
  logic f2_present;

  always_comb begin
    f1_present = (f1 >= MIN_VAL);
    f2_present = (f2 >= MIN_VAL);
    dominant   = DOM_NONE;
    if (f1_present && f2_present) begin
      if (f1 > f2)      dominant = DOM_F1;
      else if (f2 > f1) dominant = DOM_F2;
      else              dominant = DOM_EQUAL;
    end else if (f1_present) begin
      dominant = DOM_F1;
    end else if (f2_present) begin
      dominant = DOM_F2;
    end
  end

endmodule

// File: rtl/frequency_analyzer_sequencer.sv
// rtl/frequency_analyzer_sequencer.sv - gated measurement controller for frequency_analyzer
//
// Purpose : per start request, clears the analyzer, enables it for a gate
//           window, lets the counters settle, then latches both tone counts
//           and the dominant-tone code.
// Ports   : clock, reset_n (async, active-low)
//           start, abort             - run request / cancel
//           f1_value, f2_value       - analyzer counts
//           analyzer_enable/clear    - analyzer controls (sole driver)
//           busy, done               - status; done pulses when results update
//           f1_result, f2_result, dominant - latched results
// Config  : FREQ_ANALYZER_SEQ_CONTINUOUS_EN adds input continuous; while it
//           is high, LATCH goes straight back to CLEAR.
module frequency_analyzer_sequencer
  import freq_analyzer_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned GATE_CYCLES   = 5000000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MIN_COUNT     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] f1_value,
  input  logic [COUNT_W-1:0] f2_value,
`ifdef FREQ_ANALYZER_SEQ_CONTINUOUS_EN
  input  logic               continuous,
`endif
  output logic               analyzer_enable,
  output logic               analyzer_clear,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] f1_result,
  output logic [COUNT_W-1:0] f2_result,
  output logic [1:0]         dominant
);

  localparam logic [COUNT_W-1:0] CLEAR_LOAD  = COUNT_W'(CLEAR_CYCLES - 1);
  localparam logic [COUNT_W-1:0] GATE_LOAD   = COUNT_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] SETTLE_LOAD = COUNT_W'(SETTLE_CYCLES - 1);

  seq_state_t         state;
  seq_state_t         next_state;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_next;
  logic               repeat_run;
  logic               abort_exit;

  logic               enable_next;
  logic               clear_next;
  logic               busy_next;
  logic               done_next;
  logic [1:0]         dom_comb;

`ifdef FREQ_ANALYZER_SEQ_CONTINUOUS_EN
  assign repeat_run = continuous;
`else
  assign repeat_run = 1'b0;
`endif

  // Abort only matters while a run is actually timing something.
  assign abort_exit = abort && is_timed(state);

  freq_dominance_classifier #(
    .MIN_COUNT (MIN_COUNT)
  ) u_classifier (
    .f1       (f1_value),
    .f2       (f2_value),
    .dominant (dom_comb)
  );

  // State register, counter and registered outputs. Outputs are computed
  // from next_state so each one changes on the same edge as the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      analyzer_enable <= 1'b0;
      analyzer_clear  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      f1_result       <= '0;
      f2_result       <= '0;
      dominant        <= DOM_NONE;
    end else begin
      state           <= next_state;
      cnt             <= cnt_next;
      analyzer_enable <= enable_next;
      analyzer_clear  <= clear_next;
      busy            <= busy_next;
      done            <= done_next;
      if (done_next) begin
        f1_result <= f1_value;
        f2_result <= f2_value;
        dominant  <= dom_comb;
      end
    end
  end

  // Next-state and counter.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !abort) next_state = CLEAR;
      CLEAR:   if (abort)           next_state = IDLE;
               else if (cnt == '0)  next_state = GATE;
      GATE:    if (abort)           next_state = IDLE;
               else if (cnt == '0)  next_state = SETTLE;
      SETTLE:  if (abort)           next_state = IDLE;
               else if (cnt == '0)  next_state = LATCH;
      LATCH:   next_state = repeat_run ? CLEAR : IDLE;
      default: next_state = IDLE;
    endcase

    // Load N-1 on entry to a timed state, otherwise count down to zero.
    cnt_next = cnt;
    if (next_state != state) begin
      case (next_state)
        CLEAR:   cnt_next = CLEAR_LOAD;
        GATE:    cnt_next = GATE_LOAD;
        SETTLE:  cnt_next = SETTLE_LOAD;
        default: cnt_next = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_next = cnt - COUNT_W'(1);
    end
  end

  // Output decode. An abort forces a single clear cycle so the analyzer
  // is left in a known state; enable drops because next_state is IDLE.
  always_comb begin
    enable_next = (next_state == GATE);
    clear_next  = (next_state == CLEAR) || abort_exit;
    busy_next   = (next_state != IDLE);
    done_next   = (next_state == LATCH);
  end

endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// tb/tb_frequency_analyzer_sequencer.sv - directed self-checking bench for frequency_analyzer_sequencer
module tb_frequency_analyzer_sequencer;

  localparam int C = 4;
  localparam int G = 100;
  localparam int S = 2;
  localparam int LAT = C + G + S + 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] f1_value = '0;
  logic [31:0] f2_value = '0;
`ifdef FREQ_ANALYZER_SEQ_CONTINUOUS_EN
  logic        continuous = 1'b0;
`endif
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic        busy;
  logic        done;
  logic [31:0] f1_result;
  logic [31:0] f2_result;
  logic [1:0]  dominant;

  int errors = 0;
  int checks = 0;

  frequency_analyzer_sequencer #(
    .CLEAR_CYCLES  (C),
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .MIN_COUNT     (16)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .f1_value        (f1_value),
    .f2_value        (f2_value),
`ifdef FREQ_ANALYZER_SEQ_CONTINUOUS_EN
    .continuous      (continuous),
`endif
    .analyzer_enable (analyzer_enable),
    .analyzer_clear  (analyzer_clear),
    .busy            (busy),
    .done            (done),
    .f1_result       (f1_result),
    .f2_result       (f2_result),
    .dominant        (dominant)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives start for one edge; on return the bench sits in cycle t+1.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starting in cycle k=1 of a run, advances until done is seen.
  task automatic wait_done(input int budget, output int k, output bit found);
    found = 1'b0;
    k = 1;
    while (k <= budget) begin
      if (done) begin
        found = 1'b1;
        return;
      end
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({analyzer_enable, analyzer_clear, busy, done, dominant} !== 6'b0 ||
        f1_result !== 32'd0 || f2_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b clr=%b busy=%b done=%b dom=%0d f1=%0d f2=%0d required all 0",
               analyzer_enable, analyzer_clear, busy, done, dominant, f1_result, f2_result);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_timing();
    logic [3:0] got;
    logic [3:0] exp;
    f1_value = 32'd50;
    f2_value = 32'd20;
    start_run();
    for (int k = 1; k <= LAT + 2; k++) begin
      exp[3] = (k >= 1) && (k <= C);
      exp[2] = (k >= C + 1) && (k <= C + G);
      exp[1] = (k <= LAT);
      exp[0] = (k == LAT);
      got = {analyzer_clear, analyzer_enable, busy, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL timing k=%0d: clr/en/busy/done=%b required %b", k, got, exp);
      end
      if (k == LAT) begin
        checks++;
        if (f1_result !== 32'd50 || f2_result !== 32'd20 || dominant !== 2'd1) begin
          errors++;
          $display("FAIL timing_results: f1=%0d f2=%0d dom=%0d required 50 20 1",
                   f1_result, f2_result, dominant);
        end
      end
      tick();
    end
  endtask

  task automatic run_measure(input logic [31:0] a, input logic [31:0] b, input logic [1:0] exp_dom,
                             input string name);
    int k;
    bit found;
    f1_value = a;
    f2_value = b;
    start_run();
    wait_done(LAT + 20, k, found);
    checks++;
    if (!found || k != LAT) begin
      errors++;
      $display("FAIL %s_latency: done at k=%0d found=%0d required k=%0d", name, k, found, LAT);
    end
    checks++;
    if (f1_result !== a || f2_result !== b || dominant !== exp_dom) begin
      errors++;
      $display("FAIL %s_result: f1=%0d f2=%0d dom=%0d required %0d %0d %0d",
               name, f1_result, f2_result, dominant, a, b, exp_dom);
    end
    repeat (2) tick();
  endtask

  task automatic test_dominance();
    run_measure(32'd10, 32'd10, 2'd0, "dom_both_absent");
    run_measure(32'd30, 32'd30, 2'd3, "dom_equal");
    run_measure(32'd16, 32'd15, 2'd1, "dom_f1_at_min");
    run_measure(32'd15, 32'd16, 2'd2, "dom_f2_at_min");
    run_measure(32'd40, 32'd100, 2'd2, "dom_f2_larger");
    run_measure(32'hFFFF_FFFF, 32'd16, 2'd1, "dom_unsigned");
  endtask

  task automatic test_abort();
    int dones;
    f1_value = 32'd99;
    f2_value = 32'd77;
    start_run();
    // k = C+60 is the 60th gate cycle
    repeat (C + 60 - 1) tick();
    checks++;
    if (analyzer_enable !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_enable: en=%b required 1", analyzer_enable);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({analyzer_enable, analyzer_clear, busy, done} !== 4'b0100) begin
      errors++;
      $display("FAIL abort_edge: en/clr/busy/done=%b required 0100",
               {analyzer_enable, analyzer_clear, busy, done});
    end
    tick();
    checks++;
    if (analyzer_clear !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear_pulse: clr=%b busy=%b required 0 0", analyzer_clear, busy);
    end
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      if (done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d required 0", dones);
    end
    checks++;
    if (f1_result !== 32'hFFFF_FFFF || f2_result !== 32'd16 || dominant !== 2'd1) begin
      errors++;
      $display("FAIL abort_results_held: f1=%h f2=%0d dom=%0d required ffffffff 16 1",
               f1_result, f2_result, dominant);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    int done_k;
    f1_value = 32'd21;
    f2_value = 32'd64;
    start_run();
    dones = 0;
    done_k = -1;
    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        dones++;
        done_k = k;
      end
      start = (k == 50) || (k == LAT);
      tick();
    end
    start = 1'b0;
    checks++;
    if (dones !== 1 || done_k !== LAT) begin
      errors++;
      $display("FAIL start_ignored: dones=%0d at k=%0d required 1 at k=%0d", dones, done_k, LAT);
    end
    checks++;
    if (busy !== 1'b0 || dominant !== 2'd2) begin
      errors++;
      $display("FAIL start_ignored_end: busy=%b dom=%0d required 0 2", busy, dominant);
    end
  endtask

  task automatic test_abort_start_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || analyzer_clear !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: busy=%b clr=%b required 0 0", busy, analyzer_clear);
    end
    tick();
  endtask

  task automatic test_async_reset();
    start_run();
    repeat (50) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({analyzer_enable, analyzer_clear, busy, done, dominant} !== 6'b0 ||
        f1_result !== 32'd0 || f2_result !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b clr=%b busy=%b done=%b dom=%0d f1=%0d f2=%0d required all 0",
               analyzer_enable, analyzer_clear, busy, done, dominant, f1_result, f2_result);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_measure(32'd50, 32'd20, 2'd1, "after_reset");
  endtask

`ifdef FREQ_ANALYZER_SEQ_CONTINUOUS_EN
  task automatic test_continuous();
    int k1;
    int k2;
    bit found;
    f1_value = 32'd33;
    f2_value = 32'd17;
    continuous = 1'b1;
    start_run();
    wait_done(LAT + 20, k1, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL cont_first_done: not seen within budget");
    end
    tick();
    checks++;
    if (analyzer_clear !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cont_clear_follows: clr=%b busy=%b required 1 1", analyzer_clear, busy);
    end
    wait_done(LAT + 20, k2, found);
    checks++;
    if (!found || k2 !== LAT) begin
      errors++;
      $display("FAIL cont_period: %0d cycles required %0d", k2, LAT);
    end
    continuous = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || analyzer_clear !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: busy=%b clr=%b required 0 0", busy, analyzer_clear);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_dominance();
    test_abort();
    test_start_ignored();
    test_abort_start_idle();
    test_async_reset();
`ifdef FREQ_ANALYZER_SEQ_CONTINUOUS_EN
    test_continuous();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Mutual exclusion of the analyzer controls holds on every cycle.
  always @(negedge clock) begin
    if (reset_n && analyzer_enable && analyzer_clear) begin
      errors++;
      $display("FAIL enable_clear_overlap: en=%b clr=%b required not both 1",
               analyzer_enable, analyzer_clear);
    end
  end

endmodule
